// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: start/busy/done handshake and result bus
// for the sequential binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  ovf
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output ovf
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: double-dabble converter, one bit per clock,
// feeding the per-digit seven-segment decoders.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  bin_to_bcd_seq_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);

  function automatic int unsigned pow10(input int n);
    int unsigned p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  localparam int unsigned MAXV = pow10(DIGITS) - 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            st, st_n;
  logic [BIN_W-1:0]  sh_q, sh_n;
  logic [SW-1:0]     scr_q, scr_n, adj;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [BW-1:0]     bcd_q, bcd_n;
  logic              ovf_q, ovf_n;
  logic              big_q, big_n;
  logic              done_q, done_n;
  logic [SW+BIN_W-1:0] cat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      scr_q  <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      big_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_n;
      scr_q  <= scr_n;
      cnt_q  <= cnt_n;
      bcd_q  <= bcd_n;
      ovf_q  <= ovf_n;
      big_q  <= big_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    st_n   = st;
    sh_n   = sh_q;
    scr_n  = scr_q;
    cnt_n  = cnt_q;
    bcd_n  = bcd_q;
    ovf_n  = ovf_q;
    big_n  = big_q;
    done_n = 1'b0;
    // Guard bits above the visible digits count whole 10^DIGITS
    // units in binary, so only the low nibbles are adjusted.
    adj    = scr_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (adj[4*k+:4] >= 4'd5)
        adj[4*k+:4] = adj[4*k+:4] + 4'd3;
    end
    cat = {adj, sh_q} << 1;
    unique case (st)
      IDLE: begin
        if (bus.start) begin
          sh_n  = bus.bin;
          scr_n = '0;
          cnt_n = CW'(BIN_W);
          big_n = 32'(bus.bin) > MAXV;
          st_n  = SHIFT;
        end
      end
      SHIFT: begin
        scr_n = cat[SW+BIN_W-1:BIN_W];
        sh_n  = cat[BIN_W-1:0];
        cnt_n = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          st_n   = IDLE;
          done_n = 1'b1;
          ovf_n  = big_q;
          bcd_n  = big_q ? {DIGITS{4'd9}} : scr_n[BW-1:0];
        end
      end
      default: st_n = IDLE;
    endcase
  end

  assign bus.busy = (st == SHIFT);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed checks of bin_to_bcd_seq for the
// default and two alternate parameter sets.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) i1 ();
  bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) i2 ();
  bin_to_bcd_seq_if #(.BIN_W(10), .DIGITS(3)) i3 ();

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(i1.slave));
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(i2.slave));
  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(i3.slave));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic s,
                        input logic [15:0] v);
    case (sel)
      0: begin i1.start = s; i1.bin = v[7:0]; end
      1: begin i2.start = s; i2.bin = v[7:0]; end
      default: begin i3.start = s; i3.bin = v[9:0]; end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0: return i1.done;
      1: return i2.done;
      default: return i3.done;
    endcase
  endfunction

  function automatic logic [19:0] get_bcd(input int sel);
    case (sel)
      0: return 20'(i1.bcd);
      1: return 20'(i2.bcd);
      default: return 20'(i3.bcd);
    endcase
  endfunction

  function automatic logic get_ovf(input int sel);
    case (sel)
      0: return i1.ovf;
      1: return i2.ovf;
      default: return i3.ovf;
    endcase
  endfunction

  function automatic logic [19:0] ref3(input int v);
    logic [19:0] r;
    r = '0;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  // One accepted conversion; lat counts edges from acceptance to done.
  task automatic conv(input int sel, input logic [15:0] v,
                      output logic [19:0] r, output logic o,
                      output int lat, output logic dnext);
    set_in(sel, 1'b1, v);
    @(posedge clk); #1;
    set_in(sel, 1'b0, 16'h0);
    lat = 0;
    while (!get_done(sel) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = get_bcd(sel);
    o = get_ovf(sel);
    @(posedge clk); #1;
    dnext = get_done(sel);
  endtask

  logic [19:0] r;
  logic        o, dn;
  int          lat, n, prev, cyc;

  initial begin
    set_in(0, 1'b0, 16'h0);
    set_in(1, 1'b0, 16'h0);
    set_in(2, 1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(i1.busy), 32'd0);
    chk("rst_done", 32'(i1.done), 32'd0);
    chk("rst_bcd",  32'(i1.bcd),  32'd0);
    chk("rst_ovf",  32'(i1.ovf),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // bin=0: latency and busy window
    set_in(0, 1'b1, 16'd0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'd0);
    chk("busy_after_accept", 32'(i1.busy), 32'd1);
    lat = 0;
    while (!i1.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("zero_lat",  32'(lat),     32'd8);
    chk("zero_busy", 32'(i1.busy), 32'd0);
    chk("zero_bcd",  32'(i1.bcd),  32'h000);
    chk("zero_ovf",  32'(i1.ovf),  32'd0);
    @(posedge clk); #1;
    chk("zero_done_1cyc", 32'(i1.done), 32'd0);

    conv(0, 16'd255, r, o, lat, dn);
    chk("v255", 32'(r), 32'h255);
    chk("v255_lat", 32'(lat), 32'd8);
    conv(0, 16'd99, r, o, lat, dn);
    chk("v99", 32'(r), 32'h099);
    conv(0, 16'd100, r, o, lat, dn);
    chk("v100", 32'(r), 32'h100);
    conv(0, 16'd9, r, o, lat, dn);
    chk("v9", 32'(r), 32'h009);
    chk("v9_ovf", 32'(o), 32'd0);

    for (int v = 0; v < 256; v++) begin
      conv(0, 16'(v), r, o, lat, dn);
      chk("sweep_bcd", 32'(r), 32'(ref3(v)));
      chk("sweep_lat", 32'(lat), 32'd8);
      chk("sweep_dnext", 32'(dn), 32'd0);
    end

    // start held during busy is ignored
    set_in(0, 1'b1, 16'd128);
    @(posedge clk); #1;
    set_in(0, 1'b1, 16'd7);
    lat = 0;
    while (!i1.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    set_in(0, 1'b0, 16'd7);
    chk("held_lat", 32'(lat), 32'd8);
    chk("held_bcd", 32'(i1.bcd), 32'h128);
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (i1.done) n++;
    end
    chk("held_no_extra", 32'(n), 32'd0);
    conv(0, 16'd7, r, o, lat, dn);
    chk("after_held", 32'(r), 32'h007);

    // continuous start: acceptance in each done cycle
    set_in(0, 1'b1, 16'd42);
    n = 0;
    prev = -1;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (i1.done) begin
        n++;
        chk("cont_bcd", 32'(i1.bcd), 32'h042);
        if (prev >= 0) chk("cont_gap", 32'(cyc - prev), 32'd9);
        prev = cyc;
      end
    end
    chk("cont_pulses", 32'(n), 32'd6);
    set_in(0, 1'b0, 16'd0);
    repeat (12) @(posedge clk);
    #1;

    // reset mid-conversion
    set_in(0, 1'b1, 16'd200);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'd200);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(i1.busy), 32'd0);
    chk("abort_done", 32'(i1.done), 32'd0);
    chk("abort_bcd",  32'(i1.bcd),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (i1.done) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    conv(0, 16'd13, r, o, lat, dn);
    chk("after_abort", 32'(r), 32'h013);

    // DIGITS=2
    conv(1, 16'd200, r, o, lat, dn);
    chk("d2_200_bcd", 32'(r), 32'h99);
    chk("d2_200_ovf", 32'(o), 32'd1);
    conv(1, 16'd57, r, o, lat, dn);
    chk("d2_57_bcd", 32'(r), 32'h57);
    chk("d2_57_ovf", 32'(o), 32'd0);
    conv(1, 16'd99, r, o, lat, dn);
    chk("d2_99_bcd", 32'(r), 32'h99);
    chk("d2_99_ovf", 32'(o), 32'd0);
    conv(1, 16'd100, r, o, lat, dn);
    chk("d2_100_ovf", 32'(o), 32'd1);

    // BIN_W=10
    conv(2, 16'd1023, r, o, lat, dn);
    chk("w10_1023_bcd", 32'(r), 32'h999);
    chk("w10_1023_ovf", 32'(o), 32'd1);
    chk("w10_lat", 32'(lat), 32'd10);
    conv(2, 16'd999, r, o, lat, dn);
    chk("w10_999_bcd", 32'(r), 32'h999);
    chk("w10_999_ovf", 32'(o), 32'd0);
    conv(2, 16'd512, r, o, lat, dn);
    chk("w10_512_bcd", 32'(r), 32'h512);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
